// File: rtl/pll_drp_sequencer.sv
// Sequences masked read-modify-write DRP updates while holding the PLL in reset.
// Optional macro PLL_DRP_TIMEOUT_EN adds a drp_drdy watchdog that parks the FSM in an error state.
module pll_drp_sequencer #(
    parameter int unsigned DRDY_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [6:0]  req_addr_i,
    input  logic [15:0] req_data_i,
    input  logic [15:0] req_mask_i,
    input  logic        req_last_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    input  logic        pll_locked_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [3:0] {
        StIdle, StRead, StReadWait, StWrite, StWriteWait, StNext, StRelease, StWaitLock, StError
    } state_e;

    state_e      state_q;
    logic        den_q, dwe_q, pll_rst_q, last_q;
    logic [6:0]  daddr_q, addr_q;
    logic [15:0] di_q, data_q, mask_q;

`ifdef PLL_DRP_TIMEOUT_EN
    localparam int unsigned CntW = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
    logic [CntW-1:0] cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            pll_rst_q <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            last_q    <= 1'b0;
`ifdef PLL_DRP_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            den_q <= 1'b0;
            dwe_q <= 1'b0;
            unique case (state_q)
                StIdle, StNext: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        data_q    <= req_data_i;
                        mask_q    <= req_mask_i;
                        last_q    <= req_last_i;
                        daddr_q   <= req_addr_i;
                        den_q     <= 1'b1;
                        pll_rst_q <= 1'b1;
                        state_q   <= StRead;
                    end
                end
                StRead: begin
                    state_q <= StReadWait;
`ifdef PLL_DRP_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StReadWait: begin
                    if (drp_drdy_i) begin
                        // Mask bit set keeps the bit currently in the PLL register.
                        di_q    <= (drp_do_i & mask_q) | (data_q & ~mask_q);
                        daddr_q <= addr_q;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state_q <= StWrite;
`ifdef PLL_DRP_TIMEOUT_EN
                    end else if (cnt_q == CntW'(DRDY_TIMEOUT - 1)) begin
                        state_q <= StError;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                StWrite: begin
                    state_q <= StWriteWait;
`ifdef PLL_DRP_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWriteWait: begin
                    if (drp_drdy_i) begin
                        if (last_q) begin
                            pll_rst_q <= 1'b0;
                            state_q   <= StRelease;
                        end else begin
                            state_q   <= StNext;
                        end
`ifdef PLL_DRP_TIMEOUT_EN
                    end else if (cnt_q == CntW'(DRDY_TIMEOUT - 1)) begin
                        state_q <= StError;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                StRelease:  state_q <= StWaitLock;
                StWaitLock: if (pll_locked_i) state_q <= StIdle;
                StError:    state_q <= StError;
                default:    state_q <= StIdle;
            endcase
        end
    end

    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;
    assign pll_rst_o   = pll_rst_q;

    // Status decodes are gated by rst so they read as idle during the reset cycle itself.
    assign req_ready_o = !rst_i && (state_q == StIdle || state_q == StNext);
    assign busy_o      = !rst_i && !(state_q == StIdle || state_q == StError);
    assign done_o      = !rst_i && (state_q == StWaitLock) && pll_locked_i;
    assign error_o     = !rst_i && (state_q == StError);

endmodule
